// File: rtl/duplex_pkg.sv
// rtl/duplex_pkg.sv - shared codes, state enums and parity helpers for the duplex UART
package duplex_pkg;

    localparam logic [1:0] BAUD_2400  = 2'b00;
    localparam logic [1:0] BAUD_4800  = 2'b01;
    localparam logic [1:0] BAUD_9600  = 2'b10;
    localparam logic [1:0] BAUD_19200 = 2'b11;

    // Code 2'b11 is also "no parity"; anything that is not odd/even disables it.
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam int ERR_PARITY      = 0;
    localparam int ERR_FALSE_START = 1;
    localparam int ERR_STOP        = 2;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_DONE
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    function automatic logic parity_en(input logic [1:0] ptype);
        return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
    endfunction

    function automatic logic parity_bit(input logic [1:0] ptype, input logic [7:0] data);
        return (ptype == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/duplex_baud_gen.sv
// rtl/duplex_baud_gen.sv - 16x oversample tick generator for a 2-bit baud code
module duplex_baud_gen
    import duplex_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       run,
    input  logic [1:0] baud,
    output logic       tick
);

    localparam int DIV_2400  = CLK_FREQ / (2400 * 16);
    localparam int DIV_4800  = CLK_FREQ / (4800 * 16);
    localparam int DIV_9600  = CLK_FREQ / (9600 * 16);
    localparam int DIV_19200 = CLK_FREQ / (19200 * 16);
    localparam int CW        = $clog2(DIV_2400 + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] last;

    always_comb begin
        last = CW'(DIV_19200 - 1);
        case (baud)
            BAUD_2400:  last = CW'(DIV_2400 - 1);
            BAUD_4800:  last = CW'(DIV_4800 - 1);
            BAUD_9600:  last = CW'(DIV_9600 - 1);
            default:    last = CW'(DIV_19200 - 1);
        endcase
    end

    assign tick = run && (cnt == last);

    // Held at zero while idle so the first tick lands a full period after frame start.
    always_ff @(posedge clock) begin
        if (reset_n || !run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/duplex.sv
// rtl/duplex.sv - full-duplex UART top; DUPLEX_RX_SYNC_EN adds a 2-flop rx synchronizer
module duplex
    import duplex_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       send,
    input  logic [1:0] parity_type,
    input  logic [1:0] baud_rate,
    input  logic [7:0] data_transmit,
    input  logic       rx,
    output logic       tx,
    output logic       tx_active_flag,
    output logic       tx_done_flag,
    output logic       rx_active_flag,
    output logic       rx_done_flag,
    output logic [7:0] data_received,
    output logic [2:0] error_flag
);

    tx_state_t  tx_state;
    logic [7:0] tx_data;
    logic [1:0] tx_par;
    logic [1:0] tx_baud;
    logic [3:0] tx_ticks;
    logic [2:0] tx_bit;
    logic       tx_run;
    logic       tx_tick;
    logic       tx_bit_end;

    rx_state_t  rx_state;
    logic [7:0] rx_shift;
    logic [1:0] rx_par;
    logic [1:0] rx_baud;
    logic [3:0] rx_ticks;
    logic [2:0] rx_bit;
    logic       rx_par_bit;
    logic       rx_prev;
    logic       rx_s;
    logic       rx_run;
    logic       rx_tick;
    logic       rx_bit_end;

`ifdef DUPLEX_RX_SYNC_EN
    logic [1:0] rx_sync;
    always_ff @(posedge clock) begin
        if (reset_n) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], rx};
        end
    end
    assign rx_s = rx_sync[1];
`else
    assign rx_s = rx;
`endif

    assign tx_run     = (tx_state != TX_IDLE) && (tx_state != TX_DONE);
    assign tx_bit_end = tx_tick && (tx_ticks == 4'd15);
    assign rx_run     = (rx_state != RX_IDLE);
    assign rx_bit_end = rx_tick && (rx_ticks == 4'd15);

    duplex_baud_gen #(.CLK_FREQ(CLK_FREQ)) u_tx_baud (
        .clock   (clock),
        .reset_n (reset_n),
        .run     (tx_run),
        .baud    (tx_baud),
        .tick    (tx_tick)
    );

    duplex_baud_gen #(.CLK_FREQ(CLK_FREQ)) u_rx_baud (
        .clock   (clock),
        .reset_n (reset_n),
        .run     (rx_run),
        .baud    (rx_baud),
        .tick    (rx_tick)
    );

    always_ff @(posedge clock) begin
        if (reset_n) begin
            tx_state       <= TX_IDLE;
            tx             <= 1'b1;
            tx_active_flag <= 1'b0;
            tx_done_flag   <= 1'b1;
            tx_data        <= '0;
            tx_par         <= PAR_NONE;
            tx_baud        <= BAUD_2400;
            tx_ticks       <= '0;
            tx_bit         <= '0;
        end else begin
            if (tx_tick) begin
                tx_ticks <= tx_ticks + 4'd1;
            end
            case (tx_state)
                TX_IDLE: begin
                    if (send) begin
                        tx_data        <= data_transmit;
                        tx_par         <= parity_type;
                        tx_baud        <= baud_rate;
                        tx_ticks       <= '0;
                        tx_state       <= TX_START;
                        tx             <= 1'b0;
                        tx_active_flag <= 1'b1;
                        tx_done_flag   <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_state <= TX_DATA;
                        tx_bit   <= '0;
                        tx       <= tx_data[0];
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        if (tx_bit == 3'd7) begin
                            if (parity_en(tx_par)) begin
                                tx_state <= TX_PARITY;
                                tx       <= parity_bit(tx_par, tx_data);
                            end else begin
                                tx_state <= TX_STOP;
                                tx       <= 1'b1;
                            end
                        end else begin
                            tx_bit <= tx_bit + 3'd1;
                            tx     <= tx_data[tx_bit + 3'd1];
                        end
                    end
                end
                TX_PARITY: begin
                    if (tx_bit_end) begin
                        tx_state <= TX_STOP;
                        tx       <= 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end) begin
                        tx_state       <= TX_DONE;
                        tx_active_flag <= 1'b0;
                        tx_done_flag   <= 1'b1;
                    end
                end
                // One forced idle clock so the user can swap data_transmit before resampling.
                TX_DONE: tx_state <= TX_IDLE;
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n) begin
            rx_state       <= RX_IDLE;
            rx_prev        <= 1'b1;
            rx_active_flag <= 1'b0;
            rx_done_flag   <= 1'b0;
            data_received  <= '0;
            error_flag     <= '0;
            rx_shift       <= '0;
            rx_par         <= PAR_NONE;
            rx_baud        <= BAUD_2400;
            rx_ticks       <= '0;
            rx_bit         <= '0;
            rx_par_bit     <= 1'b0;
        end else begin
            rx_prev      <= rx_s;
            rx_done_flag <= 1'b0;
            if (rx_tick) begin
                rx_ticks <= rx_ticks + 4'd1;
            end
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_par   <= parity_type;
                        rx_baud  <= baud_rate;
                        rx_ticks <= '0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    // Half a bit in: a high line here means the falling edge was a glitch.
                    if (rx_tick && (rx_ticks == 4'd7)) begin
                        rx_ticks <= '0;
                        if (rx_s) begin
                            rx_state                    <= RX_IDLE;
                            error_flag[ERR_FALSE_START] <= 1'b1;
                        end else begin
                            rx_state       <= RX_DATA;
                            rx_active_flag <= 1'b1;
                            rx_bit         <= '0;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_bit_end) begin
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) begin
                            rx_state <= parity_en(rx_par) ? RX_PARITY : RX_STOP;
                        end
                    end
                end
                RX_PARITY: begin
                    if (rx_bit_end) begin
                        rx_par_bit <= rx_s;
                        rx_state   <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_bit_end) begin
                        rx_state                    <= RX_IDLE;
                        rx_active_flag              <= 1'b0;
                        rx_done_flag                <= 1'b1;
                        data_received               <= rx_shift;
                        error_flag[ERR_STOP]        <= ~rx_s;
                        error_flag[ERR_FALSE_START] <= 1'b0;
                        error_flag[ERR_PARITY]      <= parity_en(rx_par) &&
                                                       (rx_par_bit != parity_bit(rx_par, rx_shift));
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_duplex.sv
// tb/tb_duplex.sv - self-checking bench for duplex: table-driven rx frames plus tx waveform model
module tb_duplex;

    localparam int CLK_FREQ = 1_536_000;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       send = 1'b0;
    logic [1:0] parity_type = 2'b00;
    logic [1:0] baud_rate = 2'b00;
    logic [7:0] data_transmit = 8'h00;
    logic       rx;
    logic       tx;
    logic       tx_active_flag;
    logic       tx_done_flag;
    logic       rx_active_flag;
    logic       rx_done_flag;
    logic [7:0] data_received;
    logic [2:0] error_flag;

    logic       loop_en = 1'b0;
    logic       rx_drv = 1'b1;
    int         vectors = 0;
    int         miscompares = 0;
    int         rx_cnt = 0;
    logic [7:0] rx_q[$];

    assign rx = loop_en ? tx : rx_drv;

    always #5 clock = ~clock;

    duplex #(.CLK_FREQ(CLK_FREQ)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .send           (send),
        .parity_type    (parity_type),
        .baud_rate      (baud_rate),
        .data_transmit  (data_transmit),
        .rx             (rx),
        .tx             (tx),
        .tx_active_flag (tx_active_flag),
        .tx_done_flag   (tx_done_flag),
        .rx_active_flag (rx_active_flag),
        .rx_done_flag   (rx_done_flag),
        .data_received  (data_received),
        .error_flag     (error_flag)
    );

    always @(negedge clock) begin
        if (rx_done_flag === 1'b1) begin
            rx_cnt <= rx_cnt + 1;
            rx_q.push_back(data_received);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic int div_of(input logic [1:0] b);
        int hz;
        case (b)
            2'd0:    hz = 2400;
            2'd1:    hz = 4800;
            2'd2:    hz = 9600;
            default: hz = 19200;
        endcase
        return CLK_FREQ / (hz * 16);
    endfunction

    function automatic bit has_parity(input logic [1:0] p);
        return (p == 2'b01) || (p == 2'b10);
    endfunction

    // Line level of bit i of a frame: start, 8 data LSB first, optional parity, stop.
    function automatic logic model_bit(input logic [7:0] d, input logic [1:0] p, input int i);
        int ones;
        ones = 0;
        for (int j = 0; j < 8; j++) ones += d[j];
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
        if (i == 9 && has_parity(p)) return (p == 2'b01) ? ((ones % 2) == 0) : ((ones % 2) == 1);
        return 1'b1;
    endfunction

    // Entered at the negedge where send was raised; returns at the negedge of the IDLE cycle.
    task automatic tx_frame(input logic [7:0] d, input logic [1:0] p, input logic [1:0] b,
                            input logic drop_send, input logic [7:0] next_d);
        int bt;
        int nb;
        bt = 16 * div_of(b);
        nb = has_parity(p) ? 11 : 10;
        @(negedge clock);
        if (drop_send) send = 1'b0;
        for (int i = 0; i < nb; i++) begin
            int bad_tx;
            int bad_flag;
            logic want;
            bad_tx = 0;
            bad_flag = 0;
            want = model_bit(d, p, i);
            for (int k = 0; k < bt; k++) begin
                if (tx !== want) bad_tx++;
                if (tx_done_flag !== 1'b0 || tx_active_flag !== 1'b1) bad_flag++;
                @(negedge clock);
            end
            check($sformatf("tx_bit%0d_of_%h", i, d), bad_tx, 0);
            check($sformatf("tx_flags_bit%0d_of_%h", i, d), bad_flag, 0);
        end
        check("tx_done_cycle", {tx, tx_done_flag, tx_active_flag}, 3'b110);
        data_transmit = next_d;
        @(negedge clock);
        check("tx_idle_cycle", {tx, tx_done_flag, tx_active_flag}, 3'b110);
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic [1:0] p, input logic [1:0] b,
                            input logic flip, input logic stop);
        int bt;
        int nb;
        bt = 16 * div_of(b);
        nb = has_parity(p) ? 11 : 10;
        for (int i = 0; i < nb; i++) begin
            logic v;
            v = model_bit(d, p, i);
            if (i == 9 && nb == 11 && flip) v = ~v;
            if (i == nb - 1) v = stop;
            rx_drv = v;
            repeat (bt) @(negedge clock);
            if (i == 0) check("rx_active_mid_frame", rx_active_flag, 1'b1);
        end
        rx_drv = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    typedef struct {
        logic [7:0] d;
        logic [1:0] p;
        logic [1:0] b;
        logic       flip;
        logic       stop;
        logic       glitch;
        int         strobes;
        logic [7:0] exp_d;
        logic [2:0] exp_e;
    } rx_vec_t;

    rx_vec_t tbl[6];

    initial begin
        string      msg;
        int         c0;
        logic [7:0] rd;
        logic [1:0] rp;
        logic [1:0] rb;

        msg = "S:07598\n";
        tbl[0] = '{8'h4C, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 1, 8'h4C, 3'b001};
        tbl[1] = '{8'hFF, 2'b10, 2'b01, 1'b0, 1'b1, 1'b0, 1, 8'hFF, 3'b000};
        tbl[2] = '{8'h00, 2'b00, 2'b10, 1'b0, 1'b1, 1'b1, 0, 8'hFF, 3'b010};
        tbl[3] = '{8'hA5, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1, 8'hA5, 3'b100};
        tbl[4] = '{8'h3C, 2'b01, 2'b11, 1'b1, 1'b0, 1'b0, 1, 8'h3C, 3'b101};
        tbl[5] = '{8'h00, 2'b01, 2'b11, 1'b0, 1'b1, 1'b0, 1, 8'h00, 3'b000};

        repeat (3) @(negedge clock);
        check("reset_tx_flags", {tx, tx_done_flag, tx_active_flag}, 3'b110);
        check("reset_rx_flags", {rx_active_flag, rx_done_flag}, 2'b00);
        check("reset_data_received", data_received, 8'h00);
        check("reset_error_flag", error_flag, 3'b000);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);

        // 0x53 at 9600 odd, looped back.
        loop_en = 1'b1;
        parity_type = 2'b01;
        baud_rate = 2'b10;
        data_transmit = 8'h53;
        c0 = rx_cnt;
        send = 1'b1;
        tx_frame(8'h53, 2'b01, 2'b10, 1'b1, 8'h53);
        check("loop_53_strobes", rx_cnt - c0, 1);
        check("loop_53_data", data_received, 8'h53);
        check("loop_53_err", error_flag, 3'b000);

        // Back-to-back stream with send held high.
        repeat (4) @(negedge clock);
        rx_q.delete();
        data_transmit = msg[0];
        send = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tx_frame(msg[i], 2'b01, 2'b10, (i == 7), (i < 7) ? msg[i+1] : 8'h00);
        end
        repeat (4) @(negedge clock);
        check("stream_count", rx_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < rx_q.size()) check($sformatf("stream_byte%0d", i), rx_q[i], msg[i]);
        end
        check("stream_err", error_flag, 3'b000);

        // Bench-driven receive frames.
        loop_en = 1'b0;
        rx_drv = 1'b1;
        repeat (4) @(negedge clock);
        for (int r = 0; r < 6; r++) begin
            parity_type = tbl[r].p;
            baud_rate = tbl[r].b;
            c0 = rx_cnt;
            if (tbl[r].glitch) begin
                rx_drv = 1'b0;
                repeat (4 * div_of(tbl[r].b)) @(negedge clock);
                rx_drv = 1'b1;
                repeat (32 * div_of(tbl[r].b)) @(negedge clock);
            end else begin
                rx_frame(tbl[r].d, tbl[r].p, tbl[r].b, tbl[r].flip, tbl[r].stop);
            end
            check($sformatf("row%0d_strobes", r), rx_cnt - c0, tbl[r].strobes);
            check($sformatf("row%0d_data", r), data_received, tbl[r].exp_d);
            check($sformatf("row%0d_err", r), error_flag, tbl[r].exp_e);
            check($sformatf("row%0d_active", r), rx_active_flag, 1'b0);
        end

        // TX at 19200/none alongside RX at 2400/odd.
        rd = 8'($urandom);
        parity_type = 2'b00;
        baud_rate = 2'b11;
        data_transmit = rd;
        c0 = rx_cnt;
        send = 1'b1;
        fork
            tx_frame(rd, 2'b00, 2'b11, 1'b1, 8'h00);
            begin
                repeat (3) @(negedge clock);
                parity_type = 2'b01;
                baud_rate = 2'b00;
                rx_frame(8'h96, 2'b01, 2'b00, 1'b0, 1'b1);
            end
        join
        check("concurrent_strobes", rx_cnt - c0, 1);
        check("concurrent_data", data_received, 8'h96);
        check("concurrent_err", error_flag, 3'b000);

        // Random looped-back frames.
        loop_en = 1'b1;
        for (int n = 0; n < 5; n++) begin
            rd = 8'($urandom);
            rp = 2'($urandom_range(0, 3));
            rb = 2'($urandom_range(1, 3));
            repeat (3) @(negedge clock);
            parity_type = rp;
            baud_rate = rb;
            data_transmit = rd;
            c0 = rx_cnt;
            send = 1'b1;
            tx_frame(rd, rp, rb, 1'b1, 8'h00);
            check($sformatf("rand%0d_strobes", n), rx_cnt - c0, 1);
            check($sformatf("rand%0d_data", n), data_received, rd);
            check($sformatf("rand%0d_err", n), error_flag, 3'b000);
        end

        // Reset in the middle of a transmit frame.
        loop_en = 1'b0;
        parity_type = 2'b00;
        baud_rate = 2'b11;
        data_transmit = 8'h00;
        send = 1'b1;
        repeat (200) @(negedge clock);
        send = 1'b0;
        check("pre_reset_tx_active", tx_active_flag, 1'b1);
        reset_n = 1'b1;
        @(negedge clock);
        check("midframe_reset_tx", {tx, tx_done_flag, tx_active_flag}, 3'b110);
        check("midframe_reset_data", data_received, 8'h00);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        data_transmit = 8'hE7;
        send = 1'b1;
        tx_frame(8'hE7, 2'b00, 2'b11, 1'b1, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
